// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - registered, flow-controlled issue front end for the four-operation ALU
//
// Purpose: accepts tagged ALU requests on a valid/ready handshake, drives and
// holds the ALU operand/opcode inputs for the operation's settle time, samples
// the ALU result and queues {result, tag} in a show-ahead response FIFO.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_opcode/req_a/req_b/req_tag  request fields (00 add, 01 sub, 10 mult, 11 nand)
//   alu_opcode/alu_op1/alu_op2      registered drive to the combinational ALU
//   alu_result                      ALU output, sampled on the last hold cycle
//   rsp_valid/rsp_ready             response handshake
//   rsp_data/rsp_tag/rsp_zero       FIFO head result, tag and zero flag
//   busy                            an operation is in flight
module alu_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int OP      = 2,
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = 2,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP-1:0]    req_opcode,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [OP-1:0]    alu_opcode,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_zero,
    output logic             busy
);

    localparam int HOLD_W = $clog2(MUL_LAT + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [OP-1:0] OPC_MUL = OP'(2);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t              state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [TAG_W-1:0]    tag_q;
    logic [OP-1:0]       alu_opcode_q;
    logic [WIDTH-1:0]    alu_op1_q;
    logic [WIDTH-1:0]    alu_op2_q;
    logic                busy_q;

    logic [WIDTH-1:0]    fifo_data_q [DEPTH];
    logic [TAG_W-1:0]    fifo_tag_q  [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                accept;
    logic                push;
    logic                pop;

    // Room is judged on the registered count only, so a pop in the same cycle
    // does not open the door until the next cycle.
    assign req_ready = (state_q == IDLE) && (count_q < CNT_W'(DEPTH));
    assign accept    = req_valid && req_ready;
    // The ALU result is captured on the final hold cycle.
    assign push      = (state_q == EXEC) && (hold_q == HOLD_W'(1));
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid && rsp_ready;

    assign alu_opcode = alu_opcode_q;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            tag_q        <= '0;
            alu_opcode_q <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_opcode_q <= req_opcode;
                        alu_op1_q    <= req_a;
                        alu_op2_q    <= req_b;
                        tag_q        <= req_tag;
                        hold_q       <= (req_opcode == OPC_MUL) ? HOLD_W'(MUL_LAT) : HOLD_W'(1);
                        busy_q       <= 1'b1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    hold_q <= hold_q - HOLD_W'(1);
                    if (push) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is cleared on reset so the head reads zero before any push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_tag_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= alu_result;
                fifo_tag_q[wr_ptr_q]  <= tag_q;
            end
        end
    end

    assign rsp_data = fifo_data_q[rd_ptr_q];
    assign rsp_tag  = fifo_tag_q[rd_ptr_q];
    assign rsp_zero = (rsp_data == '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_tag;
    logic [1:0]  alu_opcode;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_zero;
    logic        busy;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   stream_mode = 1'b0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .WIDTH  (32),
        .OP     (2),
        .TAG_W  (4),
        .MUL_LAT(2),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opcode(req_opcode),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .alu_opcode(alu_opcode),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2: begin
                p = {32'b0, a} * {32'b0, b};
                return p[31:0];
            end
            default: return ~(a & b);
        endcase
    endfunction

    // Combinational ALU the block drives.
    assign alu_result = ref_alu(alu_opcode, alu_op1, alu_op2);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response monitor: every handshake is matched against the reference queue,
    // and a stalled head must not change.
    logic        hold_pend = 1'b0;
    logic [31:0] hold_d;
    logic [3:0]  hold_t;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stable_data", rsp_data, hold_d);
                check("stable_tag", rsp_tag, hold_t);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.d);
                    check("rsp_tag", rsp_tag, e.t);
                    check("rsp_zero", rsp_zero, (e.d == 32'd0));
                    if (stream_mode) check("stream_depth", (exp_q.size() <= 1), 1);
                end
                hold_pend = 1'b0;
            end else if (rsp_valid) begin
                hold_pend = 1'b1;
                hold_d    = rsp_data;
                hold_t    = rsp_tag;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    // Returns 1ns after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        bit ok = 1'b0;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        req_tag    = t;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back('{ref_alu(op, a, b), t});
                ok = 1'b1;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_req_ready"}, req_ready, 1);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_rsp_valid"}, rsp_valid, 0);
        check({pfx, "_rsp_data"}, rsp_data, 0);
        check({pfx, "_rsp_tag"}, rsp_tag, 0);
        check({pfx, "_rsp_zero"}, rsp_zero, 1);
        check({pfx, "_alu_opcode"}, alu_opcode, 0);
        check({pfx, "_alu_op1"}, alu_op1, 0);
        check({pfx, "_alu_op2"}, alu_op2, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 2'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        req_tag    = 4'd0;
        rsp_ready  = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Add: result one cycle after accept.
        issue(2'd0, 32'd5, 32'd3, 4'd1);
        check("add_alu_opcode", alu_opcode, 0);
        check("add_alu_op1", alu_op1, 5);
        check("add_alu_op2", alu_op2, 3);
        @(negedge clk);
        check("add_busy", busy, 1);
        check("add_req_ready_exec", req_ready, 0);
        check("add_valid_early", rsp_valid, 0);
        @(negedge clk);
        check("add_valid", rsp_valid, 1);
        check("add_data", rsp_data, 8);
        check("add_tag", rsp_tag, 1);
        check("add_zero", rsp_zero, 0);
        check("add_busy_done", busy, 0);
        check("add_req_ready_back", req_ready, 1);
        pop_one();

        // Multiply: operands held for two cycles.
        issue(2'd2, 32'd7, 32'd6, 4'd2);
        check("mul_alu_opcode", alu_opcode, 2);
        @(negedge clk);
        check("mul_busy1", busy, 1);
        check("mul_valid1", rsp_valid, 0);
        @(negedge clk);
        check("mul_busy2", busy, 1);
        check("mul_valid2", rsp_valid, 0);
        @(negedge clk);
        check("mul_busy3", busy, 0);
        check("mul_valid3", rsp_valid, 1);
        check("mul_data", rsp_data, 42);
        check("mul_tag", rsp_tag, 2);
        pop_one();

        // Wrap and zero cases.
        issue(2'd2, 32'h0001_0000, 32'h0001_0000, 4'd3);
        wait_idle();
        check("mulwrap_data", rsp_data, 0);
        check("mulwrap_zero", rsp_zero, 1);
        pop_one();
        issue(2'd1, 32'd3, 32'd5, 4'd4);
        wait_idle();
        check("sub_data", rsp_data, 32'hFFFF_FFFE);
        pop_one();
        issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5);
        wait_idle();
        check("nand_data", rsp_data, 0);
        check("nand_zero", rsp_zero, 1);
        pop_one();
        wait_drain();

        // Backpressure: four fill the FIFO, fifth waits for a pop.
        for (int i = 0; i < 4; i++) begin
            issue(2'($urandom_range(0, 3)), $urandom, $urandom, 4'(8 + i));
        end
        wait_idle();
        check("full_req_ready", req_ready, 0);
        check("full_head_tag", rsp_tag, 8);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("full_pop_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("after_pop_req_ready", req_ready, 1);
        issue(2'($urandom_range(0, 3)), $urandom, $urandom, 4'd12);
        wait_idle();
        rsp_ready = 1'b1;
        wait_drain();
        rsp_ready = 1'b0;

        // Streaming with the consumer always ready.
        stream_mode = 1'b1;
        rsp_ready   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(2'($urandom_range(0, 3)), $urandom, $urandom, 4'(i));
        end
        wait_drain();
        stream_mode = 1'b0;
        rsp_ready   = 1'b0;

        // Reset during a multiply with two responses queued.
        issue(2'd0, 32'd1, 32'd2, 4'd1);
        issue(2'd0, 32'd3, 32'd4, 4'd2);
        wait_idle();
        issue(2'd2, 32'd9, 32'd9, 4'd3);
        check("midexec_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_no_rsp", rsp_valid, 0);
        issue(2'd0, 32'd10, 32'd20, 4'd6);
        wait_drain();
        rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
